// File: rtl/cache_l1_nway.sv
// N-way set-associative, write-back/write-allocate L1 data cache with true-LRU
// replacement, a blocking miss FSM and separate write-back and fill channels.
module cache_l1_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 2,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 3
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_cpu_valid,
  input  logic                          i_cpu_we,
  input  logic [TAG_W+$clog2(SETS)-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0]             i_cpu_wdata,
  output logic                          o_cpu_ready,
  output logic                          o_cpu_done,
  output logic [DATA_W-1:0]             o_cpu_rdata,
  output logic                          o_cpu_hit,
  output logic                          o_l2_req,
  output logic [TAG_W+$clog2(SETS)-1:0] o_l2_addr,
  input  logic                          i_l2_ack,
  input  logic [DATA_W-1:0]             i_l2_rdata,
  output logic                          o_wb_valid,
  output logic [TAG_W+$clog2(SETS)-1:0] o_wb_addr,
  output logic [DATA_W-1:0]             o_wb_data,
  input  logic                          i_wb_ack,
  output logic [2+TAG_W+DATA_W:0]       o_dbg_line
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int DBG_W  = 3 + TAG_W + DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WBACK, S_FILL, S_RESP} state_t;

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [WAY_W-1:0]    r_victim;
  logic                r_cpu_ready;
  logic                r_cpu_done;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_cpu_hit;
  logic                r_l2_req;
  logic [ADDR_W-1:0]   r_l2_addr;
  logic                r_wb_valid;
  logic [ADDR_W-1:0]   r_wb_addr;
  logic [DATA_W-1:0]   r_wb_data;
  logic [DBG_W-1:0]    r_dbg_line;

  logic                r_valid [SETS][WAYS];
  logic                r_dirty [SETS][WAYS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [DATA_W-1:0]   r_data  [SETS][WAYS];
  logic [WAY_W-1:0]    r_age   [SETS][WAYS];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic                w_has_inv;
  logic [WAY_W-1:0]    w_inv_way;
  logic [WAY_W-1:0]    w_lru_way;
  logic [WAY_W-1:0]    w_victim;
  logic                w_touch;
  logic [WAY_W-1:0]    w_touch_way;
  logic [WAY_W-1:0]    w_old_age;
  logic [DATA_W-1:0]   w_hit_data;
  logic                w_hit_dirty;

  assign w_idx = r_addr[IDX_W-1:0];
  assign w_tag = r_addr[ADDR_W-1:IDX_W];

  // Descending scan so the lowest-index invalid way is the one that sticks.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    w_lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
      if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_lru_way = WAY_W'(w);
    end
  end

  assign w_victim    = w_has_inv ? w_inv_way : w_lru_way;
  assign w_touch     = ((r_state == S_LOOKUP) && w_hit) || ((r_state == S_FILL) && i_l2_ack);
  assign w_touch_way = (r_state == S_LOOKUP) ? w_hit_way : r_victim;
  assign w_old_age   = r_age[w_idx][w_touch_way];
  assign w_hit_data  = r_we ? r_wdata : r_data[w_idx][w_hit_way];
  assign w_hit_dirty = r_we | r_dirty[w_idx][w_hit_way];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_victim    <= '0;
      r_cpu_ready <= 1'b1;
      r_cpu_done  <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_hit   <= 1'b0;
      r_l2_req    <= 1'b0;
      r_l2_addr   <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_dbg_line  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      r_cpu_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cpu_valid) begin
            r_we        <= i_cpu_we;
            r_addr      <= i_cpu_addr;
            r_wdata     <= i_cpu_wdata;
            r_cpu_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (r_we) begin
              r_data[w_idx][w_hit_way]  <= r_wdata;
              r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            r_cpu_done  <= 1'b1;
            r_cpu_hit   <= 1'b1;
            r_cpu_rdata <= w_hit_data;
            r_dbg_line  <= {1'b1, w_hit_dirty, 1'b1, w_tag, w_hit_data};
            r_cpu_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_wb_valid <= 1'b1;
              r_wb_addr  <= {r_tag[w_idx][w_victim], w_idx};
              r_wb_data  <= r_data[w_idx][w_victim];
              r_state    <= S_WBACK;
            end else begin
              r_l2_req  <= 1'b1;
              r_l2_addr <= r_addr;
              r_state   <= S_FILL;
            end
          end
        end
        S_WBACK: begin
          if (i_wb_ack) begin
            r_wb_valid <= 1'b0;
            r_l2_req   <= 1'b1;
            r_l2_addr  <= r_addr;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (i_l2_ack) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= r_we;
            r_tag[w_idx][r_victim]   <= w_tag;
            r_data[w_idx][r_victim]  <= r_we ? r_wdata : i_l2_rdata;
            r_l2_req                 <= 1'b0;
            r_state                  <= S_RESP;
          end
        end
        S_RESP: begin
          r_cpu_done  <= 1'b1;
          r_cpu_hit   <= 1'b0;
          r_cpu_rdata <= r_data[w_idx][r_victim];
          r_dbg_line  <= {r_valid[w_idx][r_victim], r_dirty[w_idx][r_victim], 1'b1,
                          r_tag[w_idx][r_victim], r_data[w_idx][r_victim]};
          r_cpu_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Accessed way becomes age 0; only younger ways age by one, keeping ages unique.
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_touch_way) r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < w_old_age) r_age[w_idx][w] <= r_age[w_idx][w] + WAY_W'(1);
        end
      end
    end
  end

  assign o_cpu_ready = r_cpu_ready;
  assign o_cpu_done  = r_cpu_done;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_hit   = r_cpu_hit;
  assign o_l2_req    = r_l2_req;
  assign o_l2_addr   = r_l2_addr;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_addr   = r_wb_addr;
  assign o_wb_data   = r_wb_data;
  assign o_dbg_line  = r_dbg_line;
endmodule
